// File: rtl/count_core_pkg.sv
// count_core_pkg: shared types and defaults for the counting stage.
//   state_e     - controller state encoding (IDLE/RUN/DONE; 2'b11 is illegal)
//   COUNT_WIDTH - default width of the count register and init value
package count_core_pkg;

  localparam int unsigned COUNT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/count_core_if.sv
// count_core_if: bundle between the init-value select stage (master) and the
// counting stage (slave).
//   iCountInitValue - value picked by the select stage
//   iInitValid      - load request; the next edge loads iCountInitValue
//   iCountEn        - step enable
//   iUpDn           - 1 = up, 0 = down
//   iOneShot        - 1 = stop at terminal value, 0 = wrap
//   oCountValue     - registered count (hold value back to the select stage)
//   oCarry          - one-cycle pulse after a wrap
//   oDone           - high while in DONE
//   oState          - controller state
interface count_core_if
  import count_core_pkg::*;
#(
  parameter int unsigned CountWidth = COUNT_WIDTH
);
  logic [CountWidth-1:0] iCountInitValue;
  logic                  iInitValid;
  logic                  iCountEn;
  logic                  iUpDn;
  logic                  iOneShot;
  logic [CountWidth-1:0] oCountValue;
  logic                  oCarry;
  logic                  oDone;
  logic [1:0]            oState;

  modport master (
    output iCountInitValue, iInitValid, iCountEn, iUpDn, iOneShot,
    input  oCountValue, oCarry, oDone, oState
  );

  modport slave (
    input  iCountInitValue, iInitValid, iCountEn, iUpDn, iOneShot,
    output oCountValue, oCarry, oDone, oState
  );
endinterface

// File: rtl/count_core_step.sv
// count_step: combinational step of the count register.
//   count_i    - present count
//   up_i       - 1 = increment, 0 = decrement
//   next_o     - count +/- 1, modulo 2^CountWidth
//   terminal_o - count is at the terminal value for the chosen direction
module count_step
  import count_core_pkg::*;
#(
  parameter int unsigned CountWidth = COUNT_WIDTH
) (
  input  logic [CountWidth-1:0] count_i,
  input  logic                  up_i,
  output logic [CountWidth-1:0] next_o,
  output logic                  terminal_o
);
  always_comb begin
    if (up_i) begin
      next_o     = count_i + 1'b1;
      terminal_o = &count_i;
    end else begin
      next_o     = count_i - 1'b1;
      terminal_o = ~|count_i;
    end
  end
endmodule

// File: rtl/count_core.sv
// count_core: registered up/down counter with IDLE/RUN/DONE controller.
//   iClk    - clock, rising edge
//   _iReset - synchronous active-low reset
//   bus     - count_core_if slave modport (load/step controls in,
//             count/carry/done/state out)
module count_core
  import count_core_pkg::*;
#(
  parameter int unsigned CountWidth = COUNT_WIDTH
) (
  input  logic         iClk,
  input  logic         _iReset,
  count_core_if.slave  bus
);
  logic [CountWidth-1:0] count_q, count_d;
  logic [CountWidth-1:0] step_next;
  logic                  step_term;
  logic                  carry_q, carry_d;
  logic                  done_q, done_d;
  state_e                state_q, state_d;

  count_step #(.CountWidth(CountWidth)) u_step (
    .count_i    (count_q),
    .up_i       (bus.iUpDn),
    .next_o     (step_next),
    .terminal_o (step_term)
  );

  always_comb begin
    count_d = count_q;
    state_d = state_q;
    carry_d = 1'b0;
    done_d  = 1'b0;

    if (bus.iInitValid) begin
      count_d = bus.iCountInitValue;
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE, RUN: begin
          if (bus.iCountEn) begin
            // Terminal is judged on the pre-step count; one-shot holds it.
            if (step_term && bus.iOneShot) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              count_d = step_next;
              carry_d = step_term;
              state_d = RUN;
            end
          end else begin
            state_d = IDLE;
          end
        end
        DONE: begin
          done_d = 1'b1;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge iClk) begin
    if (!_iReset) begin
      count_q <= '0;
      state_q <= IDLE;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      state_q <= state_d;
      carry_q <= carry_d;
      done_q  <= done_d;
    end
  end

  assign bus.oCountValue = count_q;
  assign bus.oCarry      = carry_q;
  assign bus.oDone       = done_q;
  assign bus.oState      = state_q;
endmodule

// File: doc/count_core.md
# count_core

Registered counting stage directly downstream of the init-value select stage. Each cycle it either loads the select stage's chosen initial value or steps its own count register up or down, and it feeds the registered count back to the select stage as the hold value. It also runs a small IDLE/RUN/DONE controller that supports free-running wrap mode and one-shot mode, and it produces a registered carry pulse and a done flag.

## Interface
- CountWidth, 8, width of count register and init value

- iClk  input  1  clock; all state updates on rising edge
- _iReset  input  1  one clock; reset is synchronous and active-low
- iCountInitValue  input  CountWidth  value chosen by the select stage (reset/set/preload/hold priority already resolved there)
- iInitValid  input  1  high when the select stage's set, reset or load control is active; the next edge loads iCountInitValue
- iCountEn  input  1  step enable
- iUpDn  input  1  1 = count up, 0 = count down
- iOneShot  input  1  1 = stop at terminal value; 0 = wrap
- oCountValue  output  CountWidth  registered count; fed back to the select stage's hold input
- oCarry  output  1  registered one-cycle pulse, asserted the cycle after a wrap
- oDone  output  1  high while in DONE
- oState  output  2  current controller state

## Operation
Update priority on each rising edge of iClk, from highest to lowest:
- **Reset.** _iReset=0 gives count=0, state=IDLE, oCarry=0, oDone=0.
- **Load.** iInitValid=1 gives count=iCountInitValue and state=IDLE. oCarry=0 and oDone=0. This applies in any state, including DONE.
- **Terminal condition.** Terminal is (iUpDn=1 and count=2^CountWidth-1) or (iUpDn=0 and count=0). It is evaluated on the pre-step count.

Controller states:
- **IDLE (2'b00).**
  - iCountEn=1: take one step this edge, go to RUN.
  - iCountEn=0: count holds.
- **RUN (2'b01).**
  - iCountEn=1: take one step.
  - iCountEn=0: hold the count and return to IDLE.
- **DONE (2'b10).** Count holds and iCountEn is ignored. The only exits are load or reset, both to IDLE.

Step rules:
- Non-terminal step: count ±1. oCarry=0.
- Terminal step with iOneShot=0: count wraps (max→0 going up, 0→max going down). oCarry=1 for exactly one cycle. State is IDLE→RUN or stays RUN.
- Terminal step with iOneShot=1: count holds the terminal value. State goes to DONE and oDone=1. oCarry stays 0.
- Steps are modulo 2^CountWidth. There are no other widths or saturation modes.
- iUpDn and iOneShot are sampled only on stepping edges. Changing them mid-run takes effect on the next step.
- When iInitValid=1 and iCountEn=1 in the same cycle, the load wins and no step occurs.

## Timing
- Reset values: oCountValue=0, oCarry=0, oDone=0, oState=2'b00.
- Load latency: 1 cycle. oCountValue equals iCountInitValue the cycle after iInitValid=1.
- Step latency: 1 cycle per enabled edge. No pipeline bubbles; back-to-back steps are allowed.
- oCarry and oDone are registered and change on the same edge as the count that causes them.
- oCountValue is a registered output. The combinational path through the select stage back into iCountInitValue therefore contains no loop.
- Reset asserted mid-run or in DONE takes effect on the next edge and overrides load and step.

## Structure
Shared package contains:
- State encoding constants: IDLE=2'b00, RUN=2'b01, DONE=2'b10. 2'b11 is illegal and recovers to IDLE on the next edge.
- Default CountWidth=8.

One combinational sub-module, count_step. It takes count and iUpDn and returns the next value and a terminal flag. The FSM and registers stay in count_core.

## Test plan
- **Reset and load.** Reset low one edge → count 0x00, IDLE. Then iInitValid=1, iCountInitValue=0xA5 → next cycle count 0xA5, IDLE.
- **Up-count wrap.** Load 0xFE; iUpDn=1, iCountEn=1, iOneShot=0 for 3 edges → count 0xFF, 0x00, 0x01. oCarry high only in the cycle count=0x00. State is RUN.
- **Down-count one-shot.** Load 0x02; iUpDn=0, iOneShot=1, iCountEn=1 for 5 edges → 0x01, 0x00, then 0x00 held with oDone=1 and state DONE. oCarry never asserts.
- **Exit DONE.** While in DONE, iCountEn=1 → no change. iInitValid=1 with 0x10 → count 0x10, oDone=0, IDLE.
- **Simultaneous events.**
  - iInitValid=1 and iCountEn=1 with 0x33 → count 0x33, no step.
  - Reset low together with iInitValid=1 → count 0x00.
- **Pause.** In RUN at 0x40, drop iCountEn for 2 edges → count stays 0x40 and state is IDLE. Re-enable → 0x41 and state RUN.
